// File: rtl/msrv32_pkg.sv
// Shared definitions for the immediate encoder: type codes, field masks and
// the packed result of the field packer.
package msrv32_pkg;

  // Immediate type codes, same encoding as the immediate generator.
  // Codes 3'b001 and 3'b111 also decode as I-type.
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;

  // Instruction bits occupied by each type's immediate fields.
  localparam logic [31:0] MASK_I   = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S   = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B   = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U   = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J   = 32'hFFFF_F000;
  localparam logic [31:0] MASK_CSR = 32'h000F_8000;

  typedef struct packed {
    logic [31:0] bits;     // immediate bits placed in instruction positions
    logic [31:0] mask;     // instruction bits owned by the immediate
    logic        illegal;  // immediate not representable in this type
  } field_pack_t;

endpackage

// File: rtl/msrv32_imm_encoder_if.sv
// Request/response bundle for the immediate encoder.
interface msrv32_imm_encoder_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 in_valid_in;
  logic                 in_ready_out;
  logic [31:0]          imm_in;
  logic [2:0]           imm_type_in;
  logic [31:0]          base_instr_in;
  logic                 out_valid_out;
  logic                 out_ready_in;
  logic [31:0]          instr_out;
  logic                 err_out;
  logic [ERR_CNT_W-1:0] err_cnt_out;

  modport master (
    output in_valid_in, imm_in, imm_type_in, base_instr_in, out_ready_in,
    input  in_ready_out, out_valid_out, instr_out, err_out, err_cnt_out
  );

  modport slave (
    input  in_valid_in, imm_in, imm_type_in, base_instr_in, out_ready_in,
    output in_ready_out, out_valid_out, instr_out, err_out, err_cnt_out
  );
endinterface

// File: rtl/msrv32_imm_field_pack.sv
// Combinational map from (immediate, type) to instruction field bits, the
// field mask and a representability flag.
module msrv32_imm_field_pack
  import msrv32_pkg::*;
(
  input  logic [31:0] imm_i,
  input  logic [2:0]  imm_type_i,
  output field_pack_t pack_o
);

  logic [31:0] bits;
  logic [31:0] mask;
  logic        illegal;

  // Scatter immediate bits into the type's fields and range-check the value.
  always_comb begin
    bits    = '0;
    mask    = '0;
    illegal = 1'b0;
    case (imm_type_i)
      IMM_S: begin
        mask    = MASK_S;
        illegal = !((&imm_i[31:11]) | ~(|imm_i[31:11]));
        bits    = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
      end
      IMM_B: begin
        mask    = MASK_B;
        illegal = !((&imm_i[31:12]) | ~(|imm_i[31:12])) | imm_i[0];
        bits    = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
      end
      IMM_U: begin
        mask    = MASK_U;
        illegal = |imm_i[11:0];
        bits    = {imm_i[31:12], 12'b0};
      end
      IMM_J: begin
        mask    = MASK_J;
        illegal = !((&imm_i[31:20]) | ~(|imm_i[31:20])) | imm_i[0];
        bits    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
      end
      IMM_CSR: begin
        mask    = MASK_CSR;
        illegal = |imm_i[31:5];
        bits    = {12'b0, imm_i[4:0], 15'b0};
      end
      default: begin
        // IMM_I and the two alias codes
        mask    = MASK_I;
        illegal = !((&imm_i[31:11]) | ~(|imm_i[31:11]));
        bits    = {imm_i[11:0], 20'b0};
      end
    endcase
    if (illegal) begin
      bits = '0;
    end
  end

  assign pack_o = '{bits: bits, mask: mask, illegal: illegal};

endmodule

// File: rtl/msrv32_imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage 1 masks the base word and
// registers the packed fields, stage 2 merges them into the output word.
module msrv32_imm_encoder
  import msrv32_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input logic                clk_in,
  input logic                rst_n_in,
  msrv32_imm_encoder_if.slave bus
);

  field_pack_t pack;

  logic                 s1_valid_q;
  logic [31:0]          s1_base_q;
  logic [31:0]          s1_bits_q;
  logic                 s1_err_q;
  logic                 s2_valid_q;
  logic [31:0]          s2_instr_q;
  logic                 s2_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 s1_adv;
  logic                 s2_adv;

  msrv32_imm_field_pack u_pack (
    .imm_i      (bus.imm_in),
    .imm_type_i (bus.imm_type_in),
    .pack_o     (pack)
  );

  assign s2_adv           = !s2_valid_q | bus.out_ready_in;
  assign s1_adv           = !s1_valid_q | s2_adv;
  assign bus.in_ready_out = s1_adv;

  // Stage 1: capture the masked base, packed fields and range verdict.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= '0;
      s1_bits_q  <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid_in;
      if (bus.in_valid_in) begin
        s1_base_q <= bus.base_instr_in & ~pack.mask;
        s1_bits_q <= pack.bits;
        s1_err_q  <= pack.illegal;
      end
    end
  end

  // Stage 2: merge fields into the base; held while the consumer stalls.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= s1_base_q | s1_bits_q;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  // Next error count: bump on an errored output transfer, stick at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && bus.out_ready_in && s2_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_valid_out = s2_valid_q;
  assign bus.instr_out     = s2_instr_q;
  assign bus.err_out       = s2_err_q;
  assign bus.err_cnt_out   = err_cnt_q;

endmodule

// File: tb/tb_msrv32_imm_encoder.sv
// Scoreboard bench for msrv32_imm_encoder: directed vectors push expected
// words into a queue, a negedge monitor pops and compares on each transfer.
module tb_msrv32_imm_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  typ;
  } exp_t;

  logic clk;
  logic rst_n;

  msrv32_imm_encoder_if #(.ERR_CNT_W(16)) bus ();
  msrv32_imm_encoder_if #(.ERR_CNT_W(2))  bus2 ();

  msrv32_imm_encoder #(.ERR_CNT_W(16)) u_dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  msrv32_imm_encoder #(.ERR_CNT_W(2)) u_dut_sat (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus2)
  );

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic        held;
  logic [31:0] held_instr;
  logic        held_err;
  logic [15:0] cnt_model;
  int          n2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate generator (decode direction).
  function automatic logic [31:0] gen(input logic [31:0] w, input logic [2:0] t);
    logic [31:0] r;
    case (t)
      3'b010:  r = {{20{w[31]}}, w[31:25], w[11:7]};
      3'b011:  r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'b100:  r = {w[31:12], 12'b0};
      3'b101:  r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'b110:  r = {27'b0, w[19:15]};
      default: r = {{20{w[31]}}, w[31:20]};
    endcase
    return r;
  endfunction

  // Issue one request; expectation is queued at the cycle it is accepted.
  task automatic send(input logic [2:0] t, input logic [31:0] imm,
                      input logic [31:0] base, input logic [31:0] exp_instr,
                      input logic exp_err);
    exp_t e;
    bit   ok;
    bus.in_valid_in   = 1'b1;
    bus.imm_type_in   = t;
    bus.imm_in        = imm;
    bus.base_instr_in = base;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout imm=%h never accepted", imm);
    end else begin
      e.instr = exp_instr;
      e.err   = exp_err;
      e.imm   = imm;
      e.typ   = t;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid_in = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !bus.out_valid_out) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  // Monitor for the main instance: order, data, hold stability, counter.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held      = 1'b0;
      cnt_model = '0;
    end else begin
      if (held) begin
        chk("hold_instr", bus.instr_out, held_instr);
        chk("hold_err", 32'(bus.err_out), 32'(held_err));
      end
      if (bus.out_valid_out && bus.out_ready_in) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%h required=none", bus.instr_out);
        end else begin
          e = sb.pop_front();
          chk("instr", bus.instr_out, e.instr);
          chk("err", 32'(bus.err_out), 32'(e.err));
          chk("err_cnt", 32'(bus.err_cnt_out), 32'(cnt_model));
          if (!e.err) chk("closure", gen(bus.instr_out, e.typ), e.imm);
          if (e.err && cnt_model != '1) cnt_model = cnt_model + 16'd1;
        end
        held = 1'b0;
      end else if (bus.out_valid_out) begin
        held       = 1'b1;
        held_instr = bus.instr_out;
        held_err   = bus.err_out;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Monitor for the 2-bit counter instance: every word is errored.
  always @(negedge clk) begin
    if (rst_n && bus2.out_valid_out && bus2.out_ready_in) begin
      chk("sat_err", 32'(bus2.err_out), 32'd1);
      chk("sat_instr", bus2.instr_out, 32'h0000_1073);
      chk("sat_cnt_before", 32'(bus2.err_cnt_out), (n2 > 3) ? 32'd3 : 32'(n2));
      n2++;
    end
  end

  initial begin
    int acc;
    rst_n              = 1'b0;
    n2                 = 0;
    held               = 1'b0;
    cnt_model          = '0;
    bus.in_valid_in    = 1'b0;
    bus.imm_in         = '0;
    bus.imm_type_in    = '0;
    bus.base_instr_in  = '0;
    bus.out_ready_in   = 1'b1;
    bus2.in_valid_in   = 1'b0;
    bus2.imm_in        = '0;
    bus2.imm_type_in   = '0;
    bus2.base_instr_in = '0;
    bus2.out_ready_in  = 1'b1;

    #12 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_out), 32'd0);
    chk("rst_instr", bus.instr_out, 32'd0);
    chk("rst_err", 32'(bus.err_out), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt_out), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready_out), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, full throughput.
    send(3'b000, 32'hFFFF_F812, 32'h0000_0013, 32'h8120_0013, 1'b0);
    send(3'b010, 32'h0000_0123, 32'h0000_2023, 32'h1200_21A3, 1'b0);
    send(3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    send(3'b101, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    send(3'b011, 32'h0000_0010, 32'h0000_0063, 32'h0000_0863, 1'b0);
    send(3'b011, 32'h0000_0011, 32'h0000_0063, 32'h0000_0063, 1'b1);
    send(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h0000_0013, 1'b1);
    send(3'b111, 32'h0000_0005, 32'hFFF0_0093, 32'h0050_0093, 1'b0);
    send(3'b001, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    send(3'b100, 32'h1234_5001, 32'h0000_0037, 32'h0000_0037, 1'b1);
    send(3'b110, 32'h0000_001F, 32'h0000_1073, 32'h000F_9073, 1'b0);
    send(3'b110, 32'h0000_0020, 32'h0000_1073, 32'h0000_1073, 1'b1);
    send(3'b101, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
    send(3'b101, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 1'b1);
    send(3'b011, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0);
    send(3'b010, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 1'b0);
    drain();
    chk("err_cnt_after_vectors", 32'(bus.err_cnt_out), 32'd5);

    // Backpressure: five I-type requests while the consumer stalls 4 cycles.
    bus.out_ready_in = 1'b0;
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          send(3'b000, 32'(k), 32'h0000_0013, {12'(k), 20'h00013}, 1'b0);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        chk("bp_in_ready_full", 32'(bus.in_ready_out), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid_out), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready_in = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two words in flight.
    bus.out_ready_in = 1'b0;
    send(3'b000, 32'h0000_0009, 32'h0000_0013, 32'h0090_0013, 1'b0);
    send(3'b011, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 32'(bus.out_valid_out), 32'd0);
    chk("arst_instr", bus.instr_out, 32'd0);
    chk("arst_err_cnt", 32'(bus.err_cnt_out), 32'd0);
    chk("arst_err", 32'(bus.err_out), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency of the first request after reset release.
    bus.out_ready_in = 1'b1;
    fork
      send(3'b000, 32'h0000_0007, 32'h0000_0013, 32'h0070_0013, 1'b0);
      begin
        @(posedge clk);
        #2;
        chk("lat_cycle1", 32'(bus.out_valid_out), 32'd0);
        @(posedge clk);
        #2;
        chk("lat_cycle2", 32'(bus.out_valid_out), 32'd1);
      end
    join
    drain();

    // Saturation on the 2-bit counter instance.
    bus2.imm_type_in   = 3'b110;
    bus2.imm_in        = 32'h0000_0020;
    bus2.base_instr_in = 32'h0000_1073;
    acc = 0;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      bus2.in_valid_in = 1'b1;
      @(negedge clk);
      if (bus2.in_ready_out) acc++;
      @(posedge clk);
      #1;
    end
    bus2.in_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_accepted", 32'(acc), 32'd5);
    chk("sat_outputs", 32'(n2), 32'd5);
    chk("sat_final_cnt", 32'(bus2.err_cnt_out), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
